// File: rtl/add_seq_pkg.sv
// add_seq shared types: operation encodings and controller states.
// Imported by add_seq and add_chunk.
package add_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_RSUB  = 2'b10,
      OP_ADDNC = 2'b11
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational W-bit adder slice.
// Ports: a, b (W), ci (1) -> s (W), co (1).
module add_chunk
   import add_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/add_seq.sv
// add_seq: clocked N-bit add/sub/rsub, W bits per clock, req/fin handshake.
// Ports: clk, rst_n (async low), req, op[1:0], cin, x[N], y[N],
//   sat (only with ADD_SEQ_SAT_EN) -> fin, so[N], couto, ovf, zero.
module add_seq
   import add_seq_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req,
   input  logic [1:0]   op,
   input  logic         cin,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
`ifdef ADD_SEQ_SAT_EN
   input  logic         sat,
`endif
   output logic         fin,
   output logic [N-1:0] so,
   output logic         couto,
   output logic         ovf,
   output logic         zero
);

   localparam int K  = N / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   generate
      if ((N % W) != 0) begin : g_bad_w
         $error("add_seq: N must be a multiple of W");
      end
   endgenerate

   state_e         state_q, state_d;
   logic           req_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic           carry_q, carry_d;
   logic [N-1:0]   stage_q, stage_d;
   logic           fin_q, fin_d;
   logic [N-1:0]   so_q, so_d;
   logic           couto_q, couto_d;
   logic           ovf_q, ovf_d;
   logic           zero_q, zero_d;
`ifdef ADD_SEQ_SAT_EN
   logic           sat_q, sat_d;
`endif

   logic           start;
   int             base;
   logic [W-1:0]   ch_a, ch_b, ch_s;
   logic           ch_co;
   logic [N-1:0]   sum_full;
   logic [N-1:0]   res;
   logic           ovf_w;

   add_chunk #(.W(W)) u_chunk (
      .a  (ch_a),
      .b  (ch_b),
      .ci (carry_q),
      .s  (ch_s),
      .co (ch_co)
   );

   assign start = req & ~req_q & (state_q == IDLE);
   assign base  = W * int'(cnt_q);
   assign ch_a  = a_q[base +: W];
   assign ch_b  = b_q[base +: W];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      stage_d  = stage_q;
      fin_d    = fin_q;
      so_d     = so_q;
      couto_d  = couto_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
`ifdef ADD_SEQ_SAT_EN
      sat_d    = sat_q;
`endif
      sum_full = stage_q;
      sum_full[base +: W] = ch_s;
      ovf_w    = (a_q[N-1] == b_q[N-1]) &
                 (sum_full[N-1] != a_q[N-1]);
      res      = sum_full;
`ifdef ADD_SEQ_SAT_EN
      // Clamp toward the sign both operands shared.
      if (sat_q && ovf_w) begin
         res = a_q[N-1] ? {1'b1, {(N-1){1'b0}}}
                        : {1'b0, {(N-1){1'b1}}};
      end
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               unique case (op)
                  OP_ADD: begin
                     a_d = x; b_d = y; carry_d = cin;
                  end
                  OP_SUB: begin
                     a_d = x; b_d = ~y; carry_d = 1'b1;
                  end
                  OP_RSUB: begin
                     a_d = y; b_d = ~x; carry_d = 1'b1;
                  end
                  OP_ADDNC: begin
                     a_d = x; b_d = y; carry_d = 1'b0;
                  end
               endcase
`ifdef ADD_SEQ_SAT_EN
               sat_d   = sat;
`endif
               stage_d = '0;
               fin_d   = 1'b0;
               so_d    = '0;
               couto_d = 1'b0;
               ovf_d   = 1'b0;
               zero_d  = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            stage_d = sum_full;
            carry_d = ch_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(K - 1)) begin
               so_d    = res;
               couto_d = ch_co;
               ovf_d   = ovf_w;
               zero_d  = (res == '0);
               fin_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         stage_q <= '0;
         fin_q   <= 1'b1;
         so_q    <= '0;
         couto_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
`ifdef ADD_SEQ_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         stage_q <= stage_d;
         fin_q   <= fin_d;
         so_q    <= so_d;
         couto_q <= couto_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
`ifdef ADD_SEQ_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign fin   = fin_q;
   assign so    = so_q;
   assign couto = couto_q;
   assign ovf   = ovf_q;
   assign zero  = zero_q;

endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: table vectors + scoreboard queue for add_seq (N=32, W=8).
// Hand sequences cover ignored req, mid-op reset and held req.
module tb_add_seq;

   localparam int N = 32;
   localparam int W = 8;
   localparam int K = N / W;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  op;
      logic        cin;
      logic [31:0] so;
      logic        couto;
      logic        ovf;
      logic        zero;
   } vec_t;

   typedef struct {
      logic [31:0] so;
      logic        couto;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [1:0]  op;
   logic        cin;
   logic [31:0] x;
   logic [31:0] y;
   logic        sat;
   logic        fin;
   logic [31:0] so;
   logic        couto;
   logic        ovf;
   logic        zero;

   int checks   = 0;
   int failures = 0;
   exp_t sb[$];
   vec_t tbl[10];

   add_seq #(.N(N), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .op    (op),
      .cin   (cin),
      .x     (x),
      .y     (y),
`ifdef ADD_SEQ_SAT_EN
      .sat   (sat),
`endif
      .fin   (fin),
      .so    (so),
      .couto (couto),
      .ovf   (ovf),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference built from plain full-width arithmetic.
   function automatic exp_t model(input logic [31:0] xa,
                                  input logic [31:0] yb,
                                  input logic [1:0]  o,
                                  input logic        ci,
                                  input logic        st);
      exp_t e;
      logic [32:0] full;
      logic        sgn;
      sgn = xa[31];
      case (o)
         2'b00, 2'b11: begin
            full = {1'b0, xa} + {1'b0, yb} +
                   {32'd0, (o == 2'b00) ? ci : 1'b0};
            e.so    = full[31:0];
            e.couto = full[32];
            e.ovf   = (xa[31] == yb[31]) && (e.so[31] != xa[31]);
         end
         2'b01: begin
            e.so    = xa - yb;
            e.couto = (xa >= yb);
            e.ovf   = (xa[31] != yb[31]) && (e.so[31] != xa[31]);
         end
         default: begin
            e.so    = yb - xa;
            e.couto = (yb >= xa);
            e.ovf   = (xa[31] != yb[31]) && (e.so[31] != yb[31]);
            sgn     = yb[31];
         end
      endcase
`ifdef ADD_SEQ_SAT_EN
      if (st && e.ovf)
         e.so = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      if (st && sgn) e.so = e.so;
`endif
      e.zero = (e.so == 32'd0);
      return e;
   endfunction

   // Drive a request at a negedge; returns at the negedge after E0.
   task automatic start_op(input logic [31:0] xa,
                           input logic [31:0] yb,
                           input logic [1:0]  o,
                           input logic        ci,
                           input logic        hold);
      x   = xa;
      y   = yb;
      op  = o;
      cin = ci;
      req = 1'b1;
      @(negedge clk);
      if (!hold) req = 1'b0;
   endtask

   task automatic wait_result(input string nm);
      int   lat;
      exp_t e;
      lat = 0;
      while (fin == 1'b0 && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      chk({nm, "_latency"}, lat, K);
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({nm, "_so"},    so,    e.so);
         chk({nm, "_couto"}, {31'd0, couto}, {31'd0, e.couto});
         chk({nm, "_ovf"},   {31'd0, ovf},   {31'd0, e.ovf});
         chk({nm, "_zero"},  {31'd0, zero},  {31'd0, e.zero});
      end
   endtask

   initial begin
      exp_t e;
      int   busy;
      logic [31:0] hold_so;

      tbl[0] = '{32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0,
                 32'h0, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{32'd5, 32'd7, 2'b01, 1'b0,
                 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{32'd5, 32'd7, 2'b10, 1'b0,
                 32'd2, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{32'h7FFF_FFFF, 32'h1, 2'b11, 1'b1,
                 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{32'd1, 32'd2, 2'b00, 1'b1,
                 32'd4, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h1, 2'b01, 1'b0,
                 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{32'd5, 32'd5, 2'b10, 1'b0,
                 32'h0, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{32'h0000_00FF, 32'h1, 2'b00, 1'b0,
                 32'h100, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0,
                 32'h0, 1'b1, 1'b1, 1'b1};
      tbl[9] = '{32'h00FF_FF00, 32'h0000_0100, 2'b01, 1'b0,
                 32'h00FF_FE00, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      req   = 1'b0;
      op    = 2'b00;
      cin   = 1'b0;
      x     = '0;
      y     = '0;
      sat   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_fin",   {31'd0, fin},   32'd1);
      chk("rst_so",    so,             32'd0);
      chk("rst_couto", {31'd0, couto}, 32'd0);
      chk("rst_ovf",   {31'd0, ovf},   32'd0);
      chk("rst_zero",  {31'd0, zero},  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         sb.push_back('{tbl[i].so, tbl[i].couto,
                        tbl[i].ovf, tbl[i].zero});
         start_op(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].cin, 1'b0);
         wait_result($sformatf("vec%0d", i));
         @(negedge clk);
      end

      for (int i = 0; i < 8; i++) begin
         logic [31:0] rx, ry;
         logic [1:0]  ro;
         logic        rc;
         rx = $urandom;
         ry = $urandom;
         ro = 2'($urandom_range(0, 3));
         rc = 1'($urandom_range(0, 1));
         sb.push_back(model(rx, ry, ro, rc, 1'b0));
         start_op(rx, ry, ro, rc, 1'b0);
         wait_result($sformatf("rnd%0d", i));
      end

`ifdef ADD_SEQ_SAT_EN
      sat = 1'b1;
      sb.push_back('{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
      start_op(32'h7FFF_FFFF, 32'h1, 2'b11, 1'b0, 1'b0);
      wait_result("sat_pos");
      sb.push_back(model(32'h8000_0000, 32'h1, 2'b01, 1'b0, 1'b1));
      start_op(32'h8000_0000, 32'h1, 2'b01, 1'b0, 1'b0);
      wait_result("sat_sub");
      sat = 1'b0;
`endif

      // Second rising req two clocks into RUN must be dropped.
      sb.push_back('{32'd30, 1'b0, 1'b0, 1'b0});
      start_op(32'd10, 32'd20, 2'b00, 1'b0, 1'b0);
      fork
         begin
            @(negedge clk);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
         end
      join_none
      wait_result("ign");
      busy = 0;
      repeat (8) begin
         @(negedge clk);
         if (!fin) busy++;
      end
      chk("ign_no_restart", busy, 0);
      chk("ign_so_held", so, 32'd30);
      chk("ign_sb_drained", sb.size(), 0);

      // Reset during RUN aborts and forces idle outputs at once.
      start_op(32'd100, 32'd200, 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_fin", {31'd0, fin}, 32'd1);
      chk("arst_so",  so,           32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sb.push_back('{32'd8, 1'b0, 1'b0, 1'b0});
      start_op(32'd3, 32'd4, 2'b00, 1'b1, 1'b0);
      wait_result("post_rst");

      // req held across completion: no restart until it falls.
      e = model(32'h1234_0000, 32'h0000_5678, 2'b00, 1'b0, 1'b0);
      sb.push_back(e);
      start_op(32'h1234_0000, 32'h0000_5678, 2'b00, 1'b0, 1'b1);
      wait_result("held");
      hold_so = so;
      x = 32'hDEAD_BEEF;
      busy = 0;
      repeat (6) begin
         @(negedge clk);
         if (!fin) busy++;
      end
      chk("held_no_restart", busy, 0);
      chk("held_so", hold_so, 32'h1234_5678);
      req = 1'b0;
      @(negedge clk);
      sb.push_back('{32'h0000_0001, 1'b1, 1'b0, 1'b0});
      start_op(32'd4, 32'd3, 2'b01, 1'b0, 1'b0);
      wait_result("b2b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
